writeback_store: RTL and testbench

WRITEBACK_STORE -- requirements
Module: writeback_store

---
 rtl/writeback_store_pkg.sv | 26 ++
 rtl/dcache_write_port.sv | 76 +++++++
 rtl/writeback_store.sv | 109 ++++++++++
 tb/tb_writeback_store.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_store_pkg.sv
// Shared pipeline definitions for the writeback stage: FSM states,
// d-cache request tag constants and tag construction.
package writeback_store_pkg;

  localparam int unsigned BASE_TAG_W = 13;
  localparam int unsigned TAG_W      = BASE_TAG_W;

  // Request tag fields: direction bit, target-space bit.
  localparam logic READ   = 1'b0;
  localparam logic WRITE  = 1'b1;
  localparam logic MEMORY = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    WAIT_RESP
  } wbState_e;

  // Tag layout: {direction, space, opcode, 3'b000}.
  function automatic logic [BASE_TAG_W-1:0] makeTag(input logic isWrite,
                                                    input logic [7:0] opcode);
    return {(isWrite ? WRITE : READ), MEMORY, opcode, 3'b000};
  endfunction

endpackage

// File: rtl/dcache_write_port.sv
// Two-beat d-cache write sequencer: address beat, data beat, then wait
// for the write completion and acknowledge it for one cycle.
module dcache_write_port #(
  parameter int unsigned TAG_W = writeback_store_pkg::TAG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startIn,
  input  logic [63:0]      startAddrIn,
  input  logic [63:0]      startDataIn,
  input  logic [TAG_W-1:0] startTagIn,
  input  logic             reqackIn,
  input  logic             respcycIn,
  output logic             reqcycOut,
  output logic [63:0]      reqOut,
  output logic [TAG_W-1:0] reqtagOut,
  output logic             respackOut,
  output logic             busyOut,
  output logic             finishOut
);
  import writeback_store_pkg::*;

  wbState_e         state;
  wbState_e         nextState;
  logic [63:0]      addrQ;
  logic [63:0]      dataQ;
  logic [TAG_W-1:0] tagQ;
  logic             respackQ;
  logic             finishing;

  // State register, transaction latches and the one-cycle acknowledge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      addrQ    <= '0;
      dataQ    <= '0;
      tagQ     <= '0;
      respackQ <= 1'b0;
    end else begin
      state    <= nextState;
      respackQ <= finishing;
      if (startIn) begin
        addrQ <= startAddrIn;
        dataQ <= startDataIn;
        tagQ  <= startTagIn;
      end
    end
  end

  // Next-state decode; beats advance only on reqackIn while the request is up.
  always_comb begin
    nextState = state;
    finishing = 1'b0;
    unique case (state)
      IDLE:      if (startIn)   nextState = ADDR;
      ADDR:      if (reqackIn)  nextState = DATA;
      DATA:      if (reqackIn)  nextState = WAIT_RESP;
      WAIT_RESP: if (respcycIn) begin
        finishing = 1'b1;
        nextState = IDLE;
      end
      default:   nextState = IDLE;
    endcase
  end

  // Bus outputs derive from state and latches, so they hold while unacked.
  always_comb begin
    reqcycOut  = (state == ADDR) || (state == DATA);
    reqOut     = (state == DATA) ? dataQ : addrQ;
    reqtagOut  = tagQ;
    respackOut = respackQ;
    busyOut    = (state != IDLE);
    finishOut  = finishing;
  end

endmodule

// File: rtl/writeback_store.sv
// Writeback stage: accepts completed Memory-stage instructions, commits
// register writes, issues stores through the d-cache write port and
// counts retired instructions.
module writeback_store #(
  parameter int unsigned TAG_W = writeback_store_pkg::TAG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             opcodeValidIn,
  input  logic             isMemorySuccessfulIn,
  input  logic [7:0]       opcodeIn,
  input  logic [3:0]       destRegIn,
  input  logic             destRegValidIn,
  input  logic [63:0]      destRegValueIn,
  input  logic             isMemoryAccessDestIn,
  input  logic [63:0]      memoryAddressDestIn,
  output logic             wbStallOut,
  output logic             regWrEnOut,
  output logic [3:0]       regWrIdxOut,
  output logic [63:0]      regWrDataOut,
  output logic             reqcycOut,
  output logic [63:0]      reqOut,
  output logic [TAG_W-1:0] reqtagOut,
  input  logic             reqackIn,
  input  logic             respcycIn,
  output logic             respackOut,
  output logic [63:0]      retiredCountOut
);
  import writeback_store_pkg::*;

  logic             portBusy;
  logic             portFinish;
  logic             acceptNow;
  logic             storeAccept;
  logic             nonStoreAccept;
  logic [TAG_W-1:0] storeTag;
  logic [3:0]       heldIdx;
  logic [63:0]      heldData;
  logic             heldValid;

  // Acceptance: blocked while a store is in flight and in the cycle right
  // after a store completes (respackOut marks that cycle). The stall also
  // covers that gap so upstream keeps its instruction.
  always_comb begin
    acceptNow      = ~reset & ~portBusy & ~respackOut
                   & opcodeValidIn & isMemorySuccessfulIn;
    storeAccept    = acceptNow & isMemoryAccessDestIn;
    nonStoreAccept = acceptNow & ~isMemoryAccessDestIn;
    wbStallOut     = ~reset & (portBusy | respackOut | storeAccept);
    storeTag       = TAG_W'(makeTag(1'b1, opcodeIn));
  end

  // Destination register of the in-flight store, committed on completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      heldIdx   <= '0;
      heldData  <= '0;
      heldValid <= 1'b0;
    end else if (storeAccept) begin
      heldIdx   <= destRegIn;
      heldData  <= destRegValueIn;
      heldValid <= destRegValidIn;
    end
  end

  // Commit: one-cycle write strobe and retire count, from either a
  // non-store accept or a finished store (never both in one cycle).
  always_ff @(posedge clk) begin
    if (reset) begin
      regWrEnOut      <= 1'b0;
      regWrIdxOut     <= '0;
      regWrDataOut    <= '0;
      retiredCountOut <= '0;
    end else begin
      regWrEnOut <= 1'b0;
      if (nonStoreAccept) begin
        regWrEnOut      <= destRegValidIn;
        regWrIdxOut     <= destRegIn;
        regWrDataOut    <= destRegValueIn;
        retiredCountOut <= retiredCountOut + 64'd1;
      end else if (portFinish) begin
        regWrEnOut      <= heldValid;
        regWrIdxOut     <= heldIdx;
        regWrDataOut    <= heldData;
        retiredCountOut <= retiredCountOut + 64'd1;
      end
    end
  end

  dcache_write_port #(
    .TAG_W(TAG_W)
  ) u_writePort (
    .clk        (clk),
    .reset      (reset),
    .startIn    (storeAccept),
    .startAddrIn(memoryAddressDestIn),
    .startDataIn(destRegValueIn),
    .startTagIn (storeTag),
    .reqackIn   (reqackIn),
    .respcycIn  (respcycIn),
    .reqcycOut  (reqcycOut),
    .reqOut     (reqOut),
    .reqtagOut  (reqtagOut),
    .respackOut (respackOut),
    .busyOut    (portBusy),
    .finishOut  (portFinish)
  );

endmodule

// File: tb/tb_writeback_store.sv
// Directed bench for writeback_store: non-store commits, a two-beat store
// with delayed acks, store followed by a held non-store, reset during a
// store, counter wrap and spurious completions.
module tb_writeback_store;

  localparam int unsigned TW = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic          opcodeValidIn;
  logic          isMemorySuccessfulIn;
  logic [7:0]    opcodeIn;
  logic [3:0]    destRegIn;
  logic          destRegValidIn;
  logic [63:0]   destRegValueIn;
  logic          isMemoryAccessDestIn;
  logic [63:0]   memoryAddressDestIn;
  logic          wbStallOut;
  logic          regWrEnOut;
  logic [3:0]    regWrIdxOut;
  logic [63:0]   regWrDataOut;
  logic          reqcycOut;
  logic [63:0]   reqOut;
  logic [TW-1:0] reqtagOut;
  logic          reqackIn;
  logic          respcycIn;
  logic          respackOut;
  logic [63:0]   retiredCountOut;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  writeback_store #(.TAG_W(TW)) dut (
    .clk                 (clk),
    .reset               (reset),
    .opcodeValidIn       (opcodeValidIn),
    .isMemorySuccessfulIn(isMemorySuccessfulIn),
    .opcodeIn            (opcodeIn),
    .destRegIn           (destRegIn),
    .destRegValidIn      (destRegValidIn),
    .destRegValueIn      (destRegValueIn),
    .isMemoryAccessDestIn(isMemoryAccessDestIn),
    .memoryAddressDestIn (memoryAddressDestIn),
    .wbStallOut          (wbStallOut),
    .regWrEnOut          (regWrEnOut),
    .regWrIdxOut         (regWrIdxOut),
    .regWrDataOut        (regWrDataOut),
    .reqcycOut           (reqcycOut),
    .reqOut              (reqOut),
    .reqtagOut           (reqtagOut),
    .reqackIn            (reqackIn),
    .respcycIn           (respcycIn),
    .respackOut          (respackOut),
    .retiredCountOut     (retiredCountOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [7:0] op, input logic [3:0] rd, input logic rdv,
                       input logic [63:0] val, input logic isSt, input logic [63:0] addr);
    opcodeValidIn        = 1'b1;
    isMemorySuccessfulIn = 1'b1;
    opcodeIn             = op;
    destRegIn            = rd;
    destRegValidIn       = rdv;
    destRegValueIn       = val;
    isMemoryAccessDestIn = isSt;
    memoryAddressDestIn  = addr;
    #1;
  endtask

  task automatic noInstr();
    opcodeValidIn = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    opcodeValidIn = 1'b0; isMemorySuccessfulIn = 1'b0; opcodeIn = '0;
    destRegIn = '0; destRegValidIn = 1'b0; destRegValueIn = '0;
    isMemoryAccessDestIn = 1'b0; memoryAddressDestIn = '0;
    reqackIn = 1'b0; respcycIn = 1'b0;
    tick(); tick();

    // Reset values
    chk("rst_stall", 64'(wbStallOut), 64'd0);
    chk("rst_regWrEn", 64'(regWrEnOut), 64'd0);
    chk("rst_reqcyc", 64'(reqcycOut), 64'd0);
    chk("rst_respack", 64'(respackOut), 64'd0);
    chk("rst_req", reqOut, 64'd0);
    chk("rst_reqtag", 64'(reqtagOut), 64'd0);
    chk("rst_idx", 64'(regWrIdxOut), 64'd0);
    chk("rst_data", regWrDataOut, 64'd0);
    chk("rst_count", retiredCountOut, 64'd0);
    reset = 1'b0;
    tick();

    // Non-store: reg 3 <= 0x1234
    instr(8'h21, 4'd3, 1'b1, 64'h1234, 1'b0, 64'h0);
    chk("ns_stall", 64'(wbStallOut), 64'd0);
    tick(); noInstr();
    chk("ns_wren", 64'(regWrEnOut), 64'd1);
    chk("ns_idx", 64'(regWrIdxOut), 64'd3);
    chk("ns_data", regWrDataOut, 64'h1234);
    chk("ns_count", retiredCountOut, 64'd1);
    tick();
    chk("ns_wren_drop", 64'(regWrEnOut), 64'd0);

    // Store 0xDEAD to 0x1000, reg 7 also written; acks delayed 2 cycles
    instr(8'h5A, 4'd7, 1'b1, 64'hDEAD, 1'b1, 64'h1000);
    chk("st_accept_stall", 64'(wbStallOut), 64'd1);
    tick(); noInstr();
    chk("st_reqcyc_a", 64'(reqcycOut), 64'd1);
    chk("st_addr_beat", reqOut, 64'h1000);
    chk("st_tag", 64'(reqtagOut), 64'h1AD0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("st_addr_hold", reqOut, 64'h1000);
      chk("st_tag_hold", 64'(reqtagOut), 64'h1AD0);
      chk("st_stall_a", 64'(wbStallOut), 64'd1);
    end
    reqackIn = 1'b1; tick(); reqackIn = 1'b0;
    chk("st_data_beat", reqOut, 64'hDEAD);
    chk("st_reqcyc_d", 64'(reqcycOut), 64'd1);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("st_data_hold", reqOut, 64'hDEAD);
      chk("st_stall_d", 64'(wbStallOut), 64'd1);
    end
    reqackIn = 1'b1; tick(); reqackIn = 1'b0;
    chk("st_reqcyc_drop", 64'(reqcycOut), 64'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("st_wait_respack", 64'(respackOut), 64'd0);
      chk("st_wait_stall", 64'(wbStallOut), 64'd1);
      chk("st_wait_wren", 64'(regWrEnOut), 64'd0);
    end
    respcycIn = 1'b1; tick(); respcycIn = 1'b0;
    chk("st_respack", 64'(respackOut), 64'd1);
    chk("st_wren", 64'(regWrEnOut), 64'd1);
    chk("st_idx", 64'(regWrIdxOut), 64'd7);
    chk("st_data", regWrDataOut, 64'hDEAD);
    chk("st_count", retiredCountOut, 64'd2);
    tick();
    chk("st_respack_drop", 64'(respackOut), 64'd0);
    chk("st_wren_drop", 64'(regWrEnOut), 64'd0);

    // Store then non-store: non-store held until after the gap cycle
    instr(8'h10, 4'd1, 1'b0, 64'hBEEF, 1'b1, 64'h2000);
    tick();
    instr(8'h22, 4'd5, 1'b1, 64'h55, 1'b0, 64'h0);
    chk("hold_stall", 64'(wbStallOut), 64'd1);
    reqackIn = 1'b1; tick(); tick(); reqackIn = 1'b0;
    chk("hold_wait_wren", 64'(regWrEnOut), 64'd0);
    chk("hold_wait_count", retiredCountOut, 64'd2);
    respcycIn = 1'b1; tick(); respcycIn = 1'b0;
    chk("hold_st_respack", 64'(respackOut), 64'd1);
    chk("hold_st_wren", 64'(regWrEnOut), 64'd0);
    chk("hold_st_count", retiredCountOut, 64'd3);
    tick();
    chk("hold_gap_wren", 64'(regWrEnOut), 64'd0);
    chk("hold_gap_count", retiredCountOut, 64'd3);
    chk("hold_accept_stall", 64'(wbStallOut), 64'd0);
    tick(); noInstr();
    chk("hold_ns_wren", 64'(regWrEnOut), 64'd1);
    chk("hold_ns_idx", 64'(regWrIdxOut), 64'd5);
    chk("hold_ns_data", regWrDataOut, 64'h55);
    chk("hold_ns_count", retiredCountOut, 64'd4);
    tick();

    // Reset while waiting for the completion
    instr(8'h33, 4'd2, 1'b1, 64'h77, 1'b1, 64'h3000);
    tick(); noInstr();
    reqackIn = 1'b1; tick(); tick(); reqackIn = 1'b0;
    chk("rw_in_wait_stall", 64'(wbStallOut), 64'd1);
    reset = 1'b1; tick(); reset = 1'b0; #1;
    chk("rw_stall", 64'(wbStallOut), 64'd0);
    chk("rw_count_rst", retiredCountOut, 64'd0);
    respcycIn = 1'b1; tick(); respcycIn = 1'b0;
    chk("rw_respack", 64'(respackOut), 64'd0);
    chk("rw_wren", 64'(regWrEnOut), 64'd0);
    chk("rw_count", retiredCountOut, 64'd0);
    tick();

    // Back-to-back non-stores commit back to back
    instr(8'h01, 4'd1, 1'b1, 64'h11, 1'b0, 64'h0);
    tick();
    instr(8'h02, 4'd2, 1'b1, 64'h22, 1'b0, 64'h0);
    chk("b2b_first_data", regWrDataOut, 64'h11);
    chk("b2b_first_count", retiredCountOut, 64'd1);
    tick(); noInstr();
    chk("b2b_second_wren", 64'(regWrEnOut), 64'd1);
    chk("b2b_second_idx", 64'(regWrIdxOut), 64'd2);
    chk("b2b_second_count", retiredCountOut, 64'd2);
    tick();

    // Counter wrap; commit of an instruction with no register write
    force dut.retiredCountOut = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.retiredCountOut;
    instr(8'h44, 4'd9, 1'b0, 64'hAB, 1'b0, 64'h0);
    tick(); noInstr();
    chk("wrap_count", retiredCountOut, 64'd0);
    chk("wrap_wren", 64'(regWrEnOut), 64'd0);
    tick();

    // Spurious completion and ack in IDLE
    respcycIn = 1'b1; reqackIn = 1'b1; tick();
    respcycIn = 1'b0; reqackIn = 1'b0;
    chk("spur_respack", 64'(respackOut), 64'd0);
    chk("spur_wren", 64'(regWrEnOut), 64'd0);
    chk("spur_reqcyc", 64'(reqcycOut), 64'd0);
    tick();
    chk("spur_respack2", 64'(respackOut), 64'd0);
    chk("spur_count", retiredCountOut, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
